// File: rtl/alu_mdu.sv
// EX-stage datapath: combinational WIDTH-bit ALU plus a multi-cycle multiply/divide
// unit with HI/LO result registers and a Busy flag for the hazard unit.
module alu_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int SHW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  input  logic [SHW-1:0]   shamt,
  input  logic [2:0]       MDUOp,
  input  logic             Start,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [7:0]       MULT_LOAD = 8'(MULT_CYCLES - 1);
  localparam logic [7:0]       DIV_LOAD  = 8'(DIV_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

  logic [WIDTH-1:0]   alu_s;
  logic [WIDTH:0]     sum_ext_s;
  logic               ovf_s;

  logic [WIDTH-1:0]   hi_r, lo_r, a_r, b_r;
  logic [2:0]         op_r;
  logic [7:0]         cnt_r;
  logic               busy_r;

  logic               signed_op_s, a_neg_s, b_neg_s, div_zero_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, b_safe_s, q_mag_s, r_mag_s, quot_s, rem_s;

  // ALU result, independent of MDU state
  always_comb begin
    sum_ext_s = {SrcA[WIDTH-1], SrcA} + {SrcB[WIDTH-1], SrcB};
    ovf_s     = sum_ext_s[WIDTH] ^ sum_ext_s[WIDTH-1];
    alu_s     = ZERO;
    case (ALUControl)
      4'b0000: alu_s = SrcA + SrcB;
      4'b0001: alu_s = SrcA - SrcB;
      4'b0010: alu_s = SrcA ^ SrcB;
      4'b0011: alu_s = SrcA | SrcB;
      4'b0100: alu_s = SrcB << shamt;
      4'b0101: begin
        // a checked add that overflows passes SrcB through unchanged
        if (ovf_s) alu_s = SrcB;
        else       alu_s = sum_ext_s[WIDTH-1:0];
      end
      4'b0110: alu_s = SrcA & SrcB;
      4'b0111: alu_s = SrcB >> shamt;
      4'b1000: alu_s = $signed(SrcB) >>> shamt;
      4'b1001: alu_s = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b1010: alu_s = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      default: alu_s = ZERO;
    endcase
  end

  assign ALUResult = alu_s;

  // MDU arithmetic on the latched operands; divide works on magnitudes then fixes signs
  always_comb begin
    signed_op_s = (op_r == OP_MULT) || (op_r == OP_DIV);
    a_neg_s     = signed_op_s & a_r[WIDTH-1];
    b_neg_s     = signed_op_s & b_r[WIDTH-1];
    prod_s      = {{WIDTH{a_neg_s}}, a_r} * {{WIDTH{b_neg_s}}, b_r};
    div_zero_s  = (b_r == ZERO);
    a_mag_s     = a_neg_s ? (~a_r + ONE) : a_r;
    b_mag_s     = b_neg_s ? (~b_r + ONE) : b_r;
    b_safe_s    = div_zero_s ? ONE : b_mag_s;
    q_mag_s     = a_mag_s / b_safe_s;
    r_mag_s     = a_mag_s % b_safe_s;
    if (a_neg_s ^ b_neg_s) quot_s = ~q_mag_s + ONE;
    else                   quot_s = q_mag_s;
    if (a_neg_s) rem_s = ~r_mag_s + ONE;
    else         rem_s = r_mag_s;
  end

  // request acceptance, busy countdown and HI/LO write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r   <= ZERO;
      lo_r   <= ZERO;
      a_r    <= ZERO;
      b_r    <= ZERO;
      op_r   <= 3'b000;
      cnt_r  <= 8'd0;
      busy_r <= 1'b0;
    end else if (busy_r) begin
      if (cnt_r == 8'd0) begin
        busy_r <= 1'b0;
        case (op_r)
          OP_MULT, OP_MULTU: {hi_r, lo_r} <= prod_s;
          OP_DIV, OP_DIVU: begin
            if (!div_zero_s) begin
              hi_r <= rem_s;
              lo_r <= quot_s;
            end
          end
          default: ;
        endcase
      end else begin
        cnt_r <= cnt_r - 8'd1;
      end
    end else if (Start) begin
      case (MDUOp)
        OP_MULT, OP_MULTU: begin
          busy_r <= 1'b1;
          cnt_r  <= MULT_LOAD;
          op_r   <= MDUOp;
          a_r    <= SrcA;
          b_r    <= SrcB;
        end
        OP_DIV, OP_DIVU: begin
          busy_r <= 1'b1;
          cnt_r  <= DIV_LOAD;
          op_r   <= MDUOp;
          a_r    <= SrcA;
          b_r    <= SrcB;
        end
        OP_MTHI: hi_r <= SrcA;
        OP_MTLO: lo_r <= SrcA;
        default: ;
      endcase
    end
  end

  assign HI   = hi_r;
  assign LO   = lo_r;
  assign Busy = busy_r;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: ALU vector table, random ALU/MDU against a
// behavioural model, and hand-written multi-cycle corner sequences.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] SrcA, SrcB, ALUResult, HI, LO;
  logic [3:0]  ALUControl;
  logic [4:0]  shamt;
  logic [2:0]  MDUOp;
  logic        Start, Busy;

  logic [15:0] a16, b16, res16, hi16, lo16;
  logic [3:0]  ctl16, sh16;
  logic [2:0]  op16;
  logic        st16, busy16;

  int checks = 0;
  int failures = 0;
  logic [31:0] hi_m, lo_m;

  alu_mdu dut (
    .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .shamt(shamt), .MDUOp(MDUOp), .Start(Start), .ALUResult(ALUResult),
    .HI(HI), .LO(LO), .Busy(Busy)
  );

  alu_mdu #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .SrcA(a16), .SrcB(b16), .ALUControl(ctl16),
    .shamt(sh16), .MDUOp(op16), .Start(st16), .ALUResult(res16),
    .HI(hi16), .LO(lo16), .Busy(busy16)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] ctl, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    longint s, lim_hi, lim_lo;
    logic [31:0] r;
    lim_hi = 2147483647;
    lim_lo = -lim_hi - 1;
    s = longint'($signed(a)) + longint'($signed(b));
    case (ctl)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a ^ b;
      4'd3:  r = a | b;
      4'd4:  r = b << sh;
      4'd5:  r = (s > lim_hi || s < lim_lo) ? b : s[31:0];
      4'd6:  r = a & b;
      4'd7:  r = b >> sh;
      4'd8:  r = $signed(b) >>> sh;
      4'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd10: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // HI/LO after the operation and how many cycles Busy should stay high
  function automatic void mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo, output int n);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n = 0;
    case (op)
      3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; n = 5; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; n = 5; end
      3'd3: begin
        n = 10;
        if (b != 32'd0) begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      3'd4: begin
        n = 10;
        if (b != 32'd0) begin lo = a / b; hi = a % b; end
      end
      3'd5: hi = a;
      3'd6: lo = a;
      default: n = 0;
    endcase
  endfunction

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 300) begin
      cnt++;
      step();
    end
  endtask

  task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ohi, olo;
    int n, cnt;
    ohi = hi_m;
    olo = lo_m;
    mdu_ref(op, a, b, hi_m, lo_m, n);
    MDUOp = op; SrcA = a; SrcB = b; Start = 1'b1;
    step();
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom;
    if (n == 0) begin
      chk("busy_idle", {63'd0, Busy}, 64'd0);
    end else begin
      chk("hold_hi", {32'd0, HI}, {32'd0, ohi});
      chk("hold_lo", {32'd0, LO}, {32'd0, olo});
      wait_idle(cnt);
      chk("busy_len", 64'(cnt), 64'(n));
    end
    chk("hi", {32'd0, HI}, {32'd0, hi_m});
    chk("lo", {32'd0, LO}, {32'd0, lo_m});
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int n, input logic [15:0] ehi, input logic [15:0] elo);
    int cnt;
    op16 = op; a16 = a; b16 = b; st16 = 1'b1;
    step();
    st16 = 1'b0; a16 = 16'h5A5A; b16 = 16'hA5A5;
    cnt = 0;
    while (busy16 === 1'b1 && cnt < 300) begin
      cnt++;
      step();
    end
    chk("w16_busy_len", 64'(cnt), 64'(n));
    chk("w16_hi", {48'd0, hi16}, {48'd0, ehi});
    chk("w16_lo", {48'd0, lo16}, {48'd0, elo});
  endtask

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t tbl[12];

  initial begin
    int cnt, n;
    logic [31:0] ra, rb;
    logic [3:0]  rc;
    logic [4:0]  rs;

    tbl[0]  = '{4'b0101, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h00000001};
    tbl[1]  = '{4'b0101, 32'h00000005, 32'h00000003, 5'd0,  32'h00000008};
    tbl[2]  = '{4'b1001, 32'h00000005, 32'h00000003, 5'd0,  32'h00000000};
    tbl[3]  = '{4'b1000, 32'h00000005, 32'h80000000, 5'd4,  32'hF8000000};
    tbl[4]  = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000};
    tbl[5]  = '{4'b0001, 32'h00000003, 32'h00000005, 5'd0,  32'hFFFFFFFE};
    tbl[6]  = '{4'b1010, 32'h00000005, 32'hFFFFFFFF, 5'd0,  32'h00000001};
    tbl[7]  = '{4'b1001, 32'hFFFFFFFF, 32'h00000005, 5'd0,  32'h00000001};
    tbl[8]  = '{4'b0100, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000};
    tbl[9]  = '{4'b0111, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001};
    tbl[10] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000};
    tbl[11] = '{4'b0101, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'hFFFFFFFF};

    reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    ALUControl = 4'd0; shamt = 5'd0;
    st16 = 1'b0; op16 = 3'd0; a16 = 16'd0; b16 = 16'd0; ctl16 = 4'd0; sh16 = 4'd0;
    step(); step(); step();
    reset = 1'b0;
    hi_m = 32'd0; lo_m = 32'd0;
    chk("reset_hi", {32'd0, HI}, 64'd0);
    chk("reset_lo", {32'd0, LO}, 64'd0);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset16_busy", {63'd0, busy16}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      ALUControl = tbl[i].ctl; SrcA = tbl[i].a; SrcB = tbl[i].b; shamt = tbl[i].sh;
      #1;
      chk($sformatf("alu_tbl%0d", i), {32'd0, ALUResult}, {32'd0, tbl[i].exp});
    end

    for (int i = 0; i < 200; i++) begin
      rc = 4'($urandom_range(0, 15)); rs = 5'($urandom_range(0, 31));
      ra = $urandom; rb = $urandom;
      if (i % 4 == 0) rb = 32'h7FFFFFFF;
      ALUControl = rc; SrcA = ra; SrcB = rb; shamt = rs;
      #1;
      chk($sformatf("alu_rand_op%0d", rc), {32'd0, ALUResult}, {32'd0, alu_ref(rc, ra, rb, rs)});
    end

    run_mdu(3'd1, 32'hFFFFFFFD, 32'd7);
    chk("mult_spec_hi", {32'd0, HI}, 64'hFFFFFFFF);
    chk("mult_spec_lo", {32'd0, LO}, 64'hFFFFFFEB);
    run_mdu(3'd2, 32'hFFFFFFFF, 32'd2);
    chk("multu_spec_hi", {32'd0, HI}, 64'h1);
    chk("multu_spec_lo", {32'd0, LO}, 64'hFFFFFFFE);
    run_mdu(3'd3, 32'hFFFFFFF9, 32'd2);
    chk("div_spec_lo", {32'd0, LO}, 64'hFFFFFFFD);
    chk("div_spec_hi", {32'd0, HI}, 64'hFFFFFFFF);
    run_mdu(3'd4, 32'd7, 32'd0);
    chk("divu0_lo", {32'd0, LO}, 64'hFFFFFFFD);
    chk("divu0_hi", {32'd0, HI}, 64'hFFFFFFFF);
    run_mdu(3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("divmin_lo", {32'd0, LO}, 64'h80000000);
    chk("divmin_hi", {32'd0, HI}, 64'h0);

    // mthi issued while busy is dropped; ALU keeps working meanwhile
    MDUOp = 3'd1; SrcA = 32'd6; SrcB = 32'd7; Start = 1'b1;
    step();
    MDUOp = 3'd5; SrcA = 32'h12345678;
    step();
    Start = 1'b0;
    chk("mthi_busy_busy", {63'd0, Busy}, 64'd1);
    chk("mthi_busy_hi", {32'd0, HI}, {32'd0, hi_m});
    ALUControl = 4'd0; SrcA = 32'd10; SrcB = 32'd20;
    #1;
    chk("alu_during_busy", {32'd0, ALUResult}, 64'd30);
    wait_idle(cnt);
    hi_m = 32'd0; lo_m = 32'd42;
    chk("mthi_ignored_hi", {32'd0, HI}, 64'd0);
    chk("mthi_ignored_lo", {32'd0, LO}, 64'd42);
    run_mdu(3'd5, 32'h12345678, 32'd0);
    chk("mthi_spec_hi", {32'd0, HI}, 64'h12345678);
    run_mdu(3'd6, 32'hCAFEF00D, 32'd0);
    run_mdu(3'd7, 32'h11111111, 32'd0);
    run_mdu(3'd0, 32'h22222222, 32'd0);

    // Start held high: second mult accepted only the cycle after Busy falls
    MDUOp = 3'd1; SrcA = 32'hFFFFFFFD; SrcB = 32'd4; Start = 1'b1;
    step();
    wait_idle(cnt);
    chk("b2b_len1", 64'(cnt), 64'd5);
    chk("b2b_fall_busy", {63'd0, Busy}, 64'd0);
    chk("b2b_hi1", {32'd0, HI}, 64'hFFFFFFFF);
    chk("b2b_lo1", {32'd0, LO}, 64'hFFFFFFF4);
    SrcA = 32'd100; SrcB = 32'd200;
    step();
    Start = 1'b0;
    chk("b2b_accept2", {63'd0, Busy}, 64'd1);
    chk("b2b_hold_lo", {32'd0, LO}, 64'hFFFFFFF4);
    wait_idle(cnt);
    chk("b2b_len2", 64'(cnt), 64'd5);
    chk("b2b_hi2", {32'd0, HI}, 64'd0);
    chk("b2b_lo2", {32'd0, LO}, 64'd20000);
    hi_m = 32'd0; lo_m = 32'd20000;

    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 5 == 0) rb = 32'd0;
      if (i % 5 == 1) rb = 32'($urandom_range(1, 9));
      run_mdu(3'($urandom_range(0, 7)), ra, rb);
    end

    // reset in the third busy cycle of a div aborts it with no later write
    run_mdu(3'd5, 32'hDEADBEEF, 32'd0);
    MDUOp = 3'd3; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
    step();
    Start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_hi", {32'd0, HI}, 64'd0);
    chk("abort_lo", {32'd0, LO}, 64'd0);
    chk("abort_busy", {63'd0, Busy}, 64'd0);
    for (int i = 0; i < 12; i++) step();
    chk("abort_late_hi", {32'd0, HI}, 64'd0);
    chk("abort_late_lo", {32'd0, LO}, 64'd0);
    chk("abort_late_busy", {63'd0, Busy}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    run_mdu(3'd4, 32'd100, 32'd7);

    run16(3'd1, 16'hFED4, 16'h00FA, 1, 16'hFFFE, 16'hDB08);
    run16(3'd2, 16'hFFFF, 16'hFFFF, 1, 16'hFFFE, 16'h0001);
    run16(3'd3, 16'hFFF9, 16'h0002, 3, 16'hFFFF, 16'hFFFD);
    run16(3'd3, 16'h8000, 16'hFFFF, 3, 16'h0000, 16'h8000);
    n = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
